// File: rtl/alu_operand_router.sv
// Registered valid/ready router: steers one (A, B) operand pair per transfer into one of NUM_CH one-entry slots.
// Define ALU_ROUTER_BCAST_EN to add the in_bcast port, which loads every slot with the same pair.
module alu_operand_router #(
    parameter int WIDTH    = 16,
    parameter int SEL_BITS = 2,
    parameter int CNT_BITS = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    input  logic [SEL_BITS-1:0]        in_sel,
`ifdef ALU_ROUTER_BCAST_EN
    input  logic                       in_bcast,
`endif
    output logic [(2**SEL_BITS)-1:0]       out_valid,
    input  logic [(2**SEL_BITS)-1:0]       out_ready,
    output logic [(2**SEL_BITS)*WIDTH-1:0] out_a,
    output logic [(2**SEL_BITS)*WIDTH-1:0] out_b,
    output logic [CNT_BITS-1:0]        accept_cnt
);
    localparam int NUM_CH = 2**SEL_BITS;

    logic [NUM_CH-1:0]            full_q, full_d;
    logic [NUM_CH-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [CNT_BITS-1:0]          cnt_q, cnt_d;
    logic [NUM_CH-1:0]            drain, can_take, sel_oh, load;
    logic                         accept;

    assign drain    = full_q & out_ready;
    // A slot can take new data if it is empty or is being drained this same cycle.
    assign can_take = ~full_q | out_ready;

    always_comb begin
        sel_oh         = '0;
        sel_oh[in_sel] = 1'b1;
    end

`ifdef ALU_ROUTER_BCAST_EN
    assign in_ready = in_bcast ? (&can_take) : can_take[in_sel];
    assign accept   = in_valid & in_ready;
    assign load     = accept ? (in_bcast ? {NUM_CH{1'b1}} : sel_oh) : '0;
`else
    assign in_ready = can_take[in_sel];
    assign accept   = in_valid & in_ready;
    assign load     = accept ? sel_oh : '0;
`endif

    always_comb begin
        full_d = full_q;
        a_d    = a_q;
        b_d    = b_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (load[i]) begin
                full_d[i] = 1'b1;
                a_d[i]    = in_a;
                b_d[i]    = in_b;
            end else if (drain[i]) begin
                // Empty slots drive zero, as the old combinational demux did.
                full_d[i] = 1'b0;
                a_d[i]    = '0;
                b_d[i]    = '0;
            end
        end
        cnt_d = accept ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
        end else begin
            full_q <= full_d;
            a_q    <= a_d;
            b_q    <= b_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out_valid  = full_q;
    assign out_a      = a_q;
    assign out_b      = b_q;
    assign accept_cnt = cnt_q;
endmodule

// File: tb/tb_alu_operand_router.sv
// Directed self-checking bench for alu_operand_router (default 16-bit, 4-channel build).
// The broadcast test is compiled in only when ALU_ROUTER_BCAST_EN is defined.
module tb_alu_operand_router;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a, in_b;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid, out_ready;
    logic [63:0] out_a, out_b;
    logic [15:0] accept_cnt;
`ifdef ALU_ROUTER_BCAST_EN
    logic        in_bcast;
`endif

    int n_chk = 0;
    int n_err = 0;

    alu_operand_router dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
`ifdef ALU_ROUTER_BCAST_EN
        .in_bcast(in_bcast),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .accept_cnt(accept_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sel = '0; out_ready = '0;
`ifdef ALU_ROUTER_BCAST_EN
        in_bcast = 1'b0;
`endif
        #12;
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_a", out_a, 64'h0);
        chk("rst_cnt", 64'(accept_cnt), 64'h0);
        chk("rst_ready", 64'(in_ready), 64'h1);
        rst_n = 1'b1;
        step();

        // 1: single transfer to channel 2
        in_valid = 1'b1; in_sel = 2'd2; in_a = 16'h1234; in_b = 16'h00FF;
        step();
        in_valid = 1'b0;
        chk("t1_valid", 64'(out_valid), 64'b0100);
        chk("t1_a", out_a, 64'h0000_1234_0000_0000);
        chk("t1_b", out_b, 64'h0000_00FF_0000_0000);
        chk("t1_cnt", 64'(accept_cnt), 64'd1);

        // 2: stalled channel blocks, other channel accepts
        in_valid = 1'b1; in_sel = 2'd2; in_a = 16'h5555; in_b = 16'h6666;
        #1 chk("t2_ready_blk", 64'(in_ready), 64'h0);
        step();
        chk("t2_hold_a", out_a, 64'h0000_1234_0000_0000);
        chk("t2_hold_cnt", 64'(accept_cnt), 64'd1);
        in_sel = 2'd0; in_a = 16'hAAAA; in_b = 16'hBBBB;
        #1 chk("t2_ready_ch0", 64'(in_ready), 64'h1);
        step();
        in_valid = 1'b0;
        chk("t2_valid", 64'(out_valid), 64'b0101);
        chk("t2_a", out_a, 64'h0000_1234_0000_AAAA);
        chk("t2_cnt", 64'(accept_cnt), 64'd2);
        // drain channel 2 alone: data zero-filled, channel 0 untouched
        out_ready = 4'b0100;
        step();
        out_ready = 4'b0000;
        chk("t2_drain_valid", 64'(out_valid), 64'b0001);
        chk("t2_drain_b", out_b, 64'h0000_0000_0000_BBBB);

        // 3: back-to-back into channel 1 with out_ready[1] held
        out_ready = 4'b0010; in_valid = 1'b1; in_sel = 2'd1; in_b = 16'h0;
        for (int i = 0; i < 4; i++) begin
            in_a = 16'hA0 + 16'(i);
            #1 chk("t3_ready", 64'(in_ready), 64'h1);
            step();
            chk("t3_a1", 64'(out_a[31:16]), 64'hA0 + 64'(i));
            chk("t3_v1", 64'(out_valid[1]), 64'h1);
        end
        in_valid = 1'b0;
        chk("t3_cnt", 64'(accept_cnt), 64'd6);
        step();
        out_ready = 4'b0000;
        chk("t3_drain_valid", 64'(out_valid), 64'b0001);
        chk("t3_drain_a", out_a, 64'h0000_0000_0000_AAAA);

        // 4: asynchronous reset mid-cycle with channels 0 and 3 full
        in_valid = 1'b1; in_sel = 2'd3; in_a = 16'h3333; in_b = 16'h4444;
        step();
        in_valid = 1'b0;
        chk("t4_pre_valid", 64'(out_valid), 64'b1001);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_valid", 64'(out_valid), 64'h0);
        chk("t4_a", out_a, 64'h0);
        chk("t4_b", out_b, 64'h0);
        chk("t4_cnt", 64'(accept_cnt), 64'h0);
        #2 rst_n = 1'b1;
        step();

        // 5: counter wrap
        out_ready = 4'b1111; in_valid = 1'b1; in_sel = 2'd0; in_a = 16'h1; in_b = 16'h2;
        repeat (65535) step();
        chk("t5_cnt_max", 64'(accept_cnt), 64'hFFFF);
        step();
        chk("t5_cnt_wrap", 64'(accept_cnt), 64'h0);
        in_valid = 1'b0;
        step();
        out_ready = 4'b0000;
        chk("t5_empty", 64'(out_valid), 64'h0);

`ifdef ALU_ROUTER_BCAST_EN
        // 6: broadcast waits for every slot
        in_valid = 1'b1; in_sel = 2'd3; in_a = 16'h7777; in_b = 16'h8888;
        step();
        in_valid = 1'b0;
        in_bcast = 1'b1; in_valid = 1'b1; in_sel = 2'd0; in_a = 16'hBEEF; in_b = 16'hCAFE;
        #1 chk("t6_ready_blk", 64'(in_ready), 64'h0);
        step();
        chk("t6_cnt_blk", 64'(accept_cnt), 64'd1);
        out_ready = 4'b1000;
        #1 chk("t6_ready", 64'(in_ready), 64'h1);
        step();
        in_valid = 1'b0; in_bcast = 1'b0; out_ready = 4'b0000;
        chk("t6_valid", 64'(out_valid), 64'b1111);
        chk("t6_a", out_a, {4{16'hBEEF}});
        chk("t6_b", out_b, {4{16'hCAFE}});
        chk("t6_cnt", 64'(accept_cnt), 64'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/alu_operand_router.md
Name: alu_operand_router

Overview:
- Registered, handshaked operand router. Steers one (A, B) operand pair per transfer to one of NUM_CH ALU channels, chosen by a select field.
- Parametrised successor of the combinational 4-way ALU input demux. Adds generic width and channel count, valid/ready flow control, per-channel one-entry holding slots and an accept counter.
- Sits between the operand fetch stage and the bank of ALU units.

Parameters:
- WIDTH, 16, operand width in bits for A and B.
- SEL_BITS, 2, select width. NUM_CH = 2**SEL_BITS channels (derived localparam, not overridable).
- CNT_BITS, 16, width of the accept counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream operand pair valid.
- in_ready  output  1  router can accept the pair this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_sel  input  SEL_BITS  destination channel index.
- out_valid  output  NUM_CH  bit i = channel i slot holds a pair.
- out_ready  input  NUM_CH  bit i = channel i consumes its pair this cycle.
- out_a  output  NUM_CH*WIDTH  channel i A at bits [i*WIDTH +: WIDTH].
- out_b  output  NUM_CH*WIDTH  channel i B, same packing.
- accept_cnt  output  CNT_BITS  total accepted transfers.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all slots empty; out_valid = 0; out_a = 0; out_b = 0; accept_cnt = 0.
  - in_ready follows the ready equation below, so it is 1 while in reset. Any transfer in flight is discarded.
- Per channel i there is one slot with state EMPTY or FULL.
- Drain: drain[i] = out_valid[i] & out_ready[i].
- in_ready is combinational: in_ready = !out_valid[in_sel] | out_ready[in_sel]. It depends only on the selected channel.
- Accept: accept = in_valid & in_ready.
- Latency: on the edge where accept is high, slot[in_sel] loads in_a/in_b and goes FULL. out_valid[in_sel] rises the next cycle. Minimum latency is 1 cycle.
- Slot transitions:
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on drain without load.
  - FULL -> FULL on simultaneous drain and load to the same channel. New data replaces old with no bubble, giving full throughput per channel.
- Stability: while out_valid[i] & !out_ready[i], out_a[i] and out_b[i] hold unchanged.
- Unaffected channels: drains on channels other than in_sel proceed independently in the same cycle.
- Empty channels drive zero on out_a[i] and out_b[i]. Data is cleared on the drain edge when no load occurs, matching the demux zero-fill semantics.
- in_sel is sampled only when accept is high. in_sel and data may change freely while in_valid is low.
- Upstream must not change in_a, in_b or in_sel while in_valid & !in_ready.
- accept_cnt increments by 1 on each accept and wraps modulo 2**CNT_BITS.

Optional Feature:
- Macro: ALU_ROUTER_BCAST_EN.
- When defined:
  - an extra input port in_bcast (1 bit) exists.
  - When in_bcast = 1, in_ready = AND over all i of (!out_valid[i] | out_ready[i]).
  - On accept, every slot loads the same pair, and in_sel is ignored.
  - accept_cnt still increments by 1.
- When undefined: the port is absent and only single-channel routing exists.

Test Plan:
1. Reset, then in_valid=1, in_sel=2, A=16'h1234, B=16'h00FF, out_ready=0 -> next cycle out_valid=4'b0100, out_a[2]=16'h1234, out_b[2]=16'h00FF; other channels 0; accept_cnt=1.
2. Channel 2 full with out_ready[2]=0, send a second pair to channel 2 -> in_ready=0 and the slot holds its value. Send a pair to channel 0 instead -> accepted, out_valid=4'b0101.
3. Channel 1 full, out_ready[1]=1 held, back-to-back pairs 16'hA0..16'hA3 to channel 1 -> one accept per cycle, out_a[1] steps A0, A1, A2, A3, out_valid[1] stays 1.
4. Channels 0 and 3 full, assert rst_n=0 mid-cycle -> out_valid=0 and outputs 0 immediately with no clock edge; accept_cnt=0.
5. Preload accept_cnt to 16'hFFFF with 65535 accepts, then 1 more accept -> accept_cnt wraps to 0.
6. With ALU_ROUTER_BCAST_EN defined, in_bcast=1 and channel 3 full and stalled -> in_ready=0. Release out_ready[3] -> in_ready=1, and the next cycle out_valid=4'b1111 with identical data on all channels.
